regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, CSR).
//  Arbitrates round-robin with valid/ready handshakes and registers the winner into a one-entry write stage.
//  Suppresses x0 writes, since the register file does not check for x0 itself.
//  Exposes a pending-destination bitmap so decode can stall on hazards.
// PARAMETERS
//  DATAW    32  register data width
//  ADDRW    5   register address width
//  NUM_REQ  3   number of writeback requesters, 2..8
// PORTS
//  clock          in   1              rising-edge clock
//  reset_n        in   1              asynchronous active-low reset
//  req_valid      in   NUM_REQ        requester i has a result
//  req_ready      out  NUM_REQ        one-hot grant; handshake when valid & ready
//  req_rd         in   NUM_REQ*ADDRW  destination register; slice i = [i*ADDRW +: ADDRW]
//  req_data       in   NUM_REQ*DATAW  result data; slice i = [i*DATAW +: DATAW]
//  rf_write_enable out 1              to register file write_enable
//  rf_addr_rd     out  ADDRW          to register file addr_rd
//  rf_data_rd     out  DATAW          to register file data_rd
//  rd_addr_rs1    in   ADDRW          read address presented to register file this cycle
//  rd_addr_rs2    in   ADDRW          read address presented to register file this cycle
//  rf_data_rs1    in   DATAW          register file read data, one cycle after address
//  rf_data_rs2    in   DATAW          register file read data, one cycle after address
//  fwd_data_rs1   out  DATAW          corrected read data, aligned with rf_data_rs1
//  fwd_data_rs2   out  DATAW          corrected read data, aligned with rf_data_rs2
//  rd_pending     out  2**ADDRW       bit r set when a write to register r sits in the write stage
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - Outputs: rf_write_enable=0; rf_addr_rd=0; rf_data_rd=0; rd_pending=0.
//    - req_ready=0 while reset_n=0.
//    - Internal state: round-robin pointer=0; bypass match flags=0.
//  - Arbitration (combinational on req_valid):
//    - Grant the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
//    - At most one req_ready bit is high. No valid requester -> req_ready=0.
//    - req_ready never depends on other outputs, so there are no combinational loops.
//  - Pointer: on a handshake with requester g, the pointer becomes (g+1) mod NUM_REQ; otherwise it holds.
//  - Write stage, latency 1:
//    - Handshake at edge t -> rf_write_enable=1 at t+1, with rf_addr_rd/rf_data_rd from requester g.
//    - A new handshake may occur every cycle (full throughput, no bubbles).
//    - No handshake -> rf_write_enable=0; addr/data hold their last values.
//  - x0: a handshake with rd=0 is accepted (ready=1, consumed) but rf_write_enable stays 0 and rd_pending stays 0.
//  - rd_pending = onehot(rf_addr_rd) & {rf_write_enable}. It clears the cycle after the write.
//  - Requesters hold rd/data stable while valid and not ready; the arbiter does not check this.
//  - Reset mid-stream: the in-flight write is dropped (rf_write_enable=0 immediately, asynchronously); nothing is replayed.
// CONFIGURATION
//  - WB_BYPASS_EN defined:
//    - Register at each edge: m1 = rf_write_enable & (rf_addr_rd == rd_addr_rs1) & (rd_addr_rs1 != 0); m2 likewise for rs2.
//    - Register wd = rf_data_rd alongside them.
//    - Outputs: fwd_data_rs1 = m1 ? wd : rf_data_rs1; fwd_data_rs2 = m2 ? wd : rf_data_rs2.
//    - Effect: a read issued in the same cycle as a write returns the new value.
//  - WB_BYPASS_EN undefined:
//    - fwd_data_rs1=rf_data_rs1 and fwd_data_rs2=rf_data_rs2 (wires); no bypass flops.
//    - Decode must stall on rd_pending.
// STRUCTURE
//  - Shared package regfile_pkg: DATAW/ADDRW defaults, NUM_WB_REQ, requester index constants (WB_ALU=0, WB_LSU=1, WB_CSR=2).
//  - One sub-module, rr_arbiter (NUM_REQ: req, advance -> onehot grant); reusable for memory-port sharing.
//  - The write stage, x0 filter, rd_pending and bypass stay in this module.
// TESTING
//  1. Reset: hold reset_n=0 with all req_valid=1 -> req_ready=0, rf_write_enable=0, rd_pending=0.
//  2. Single write: requester 0 valid, rd=5, data=0xDEADBEEF -> ready[0] at t; at t+1 we=1, addr=5, data=0xDEADBEEF, rd_pending[5]=1; at t+2 we=0 and rd_pending=0.
//  3. Fairness: all 3 requesters valid continuously for 6 cycles -> grants 0,1,2,0,1,2 with we=1 on every cycle from t+1.
//  4. x0 drop: requester 1 valid, rd=0, data=0x1234 -> ready[1]=1 at t; at t+1 we=0 and rd_pending=0.
//  5. Bypass (WB_BYPASS_EN): write x7=0xA5A5A5A5 while rd_addr_rs1=7, rd_addr_rs2=7, rf_data_rs1=0 -> next cycle fwd_data_rs1=fwd_data_rs2=0xA5A5A5A5. Without the macro: fwd_data_rs1=0.
//  6. Reset mid-stream: assert reset_n=0 in the cycle after a handshake -> rf_write_enable falls immediately; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants: default widths and the writeback requester map.
package regfile_pkg;

    localparam int RF_DATAW   = 32;
    localparam int RF_ADDRW   = 5;
    localparam int NUM_WB_REQ = 3;

    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_CSR = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer;
// the pointer moves past the winner whenever advance_i reports a completed handshake.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [NUM_REQ-1:0] req_rot_s;
    logic [NUM_REQ-1:0] gnt_rot_s;

    // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_rot_s = NUM_REQ'({req_i, req_i} >> ptr_q);
        gnt_rot_s = req_rot_s & (~req_rot_s + NUM_REQ'(1));
        grant_o   = NUM_REQ'(({gnt_rot_s, gnt_rot_s} << ptr_q) >> NUM_REQ);
    end

    // Next pointer is one past the granted requester, wrapping at NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_o[i]) begin
                ptr_d = PW'((i + 1) % NUM_REQ);
            end else begin
                ptr_d = ptr_d;
            end
        end
    end

    // Pointer register, only updated on a handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with x0 filtering and a
// pending-destination bitmap. Optional read bypass of the in-flight write: WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATAW   = RF_DATAW,
    parameter int ADDRW   = RF_ADDRW,
    parameter int NUM_REQ = NUM_WB_REQ
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ADDRW-1:0] req_rd,
    input  logic [NUM_REQ*DATAW-1:0] req_data,
    output logic                     rf_write_enable,
    output logic [ADDRW-1:0]         rf_addr_rd,
    output logic [DATAW-1:0]         rf_data_rd,
    input  logic [ADDRW-1:0]         rd_addr_rs1,
    input  logic [ADDRW-1:0]         rd_addr_rs2,
    input  logic [DATAW-1:0]         rf_data_rs1,
    input  logic [DATAW-1:0]         rf_data_rs2,
    output logic [DATAW-1:0]         fwd_data_rs1,
    output logic [DATAW-1:0]         fwd_data_rs2,
    output logic [(2**ADDRW)-1:0]    rd_pending
);

    logic [NUM_REQ-1:0]    grant_s;
    logic                  hs_s;
    logic [ADDRW-1:0]      sel_rd_s;
    logic [DATAW-1:0]      sel_data_s;
    logic                  we_q, we_d;
    logic [ADDRW-1:0]      addr_q, addr_d;
    logic [DATAW-1:0]      data_q, data_d;
    logic [(2**ADDRW)-1:0] pending_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_i     (req_valid),
        .advance_i (hs_s),
        .grant_o   (grant_s)
    );

    // Grant only ever covers valid requesters, so any ready bit is a handshake.
    assign req_ready = grant_s & {NUM_REQ{reset_n}};
    assign hs_s      = |req_ready;

    // One-hot AND-OR select of the winning requester's destination and data.
    always_comb begin
        sel_rd_s   = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_rd_s   = sel_rd_s   | (req_rd[i*ADDRW +: ADDRW]   & {ADDRW{req_ready[i]}});
            sel_data_s = sel_data_s | (req_data[i*DATAW +: DATAW] & {DATAW{req_ready[i]}});
        end
    end

    // x0 results are consumed but never reach the register file.
    always_comb begin
        if (hs_s && (sel_rd_s != '0)) begin
            we_d   = 1'b1;
            addr_d = sel_rd_s;
            data_d = sel_data_s;
        end else begin
            we_d   = 1'b0;
            addr_d = addr_q;
            data_d = data_q;
        end
    end

    // One-entry write stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // Destination decode of the write currently held in the stage.
    always_comb begin
        pending_s = '0;
        if (we_q) begin
            pending_s[addr_q] = 1'b1;
        end else begin
            pending_s = '0;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_addr_rd      = addr_q;
    assign rf_data_rd      = data_q;
    assign rd_pending      = pending_s;

`ifdef WB_BYPASS_EN
    logic             m1_q, m2_q;
    logic [DATAW-1:0] wd_q;

    // Remember which read ports addressed the register being written this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m1_q <= 1'b0;
            m2_q <= 1'b0;
            wd_q <= '0;
        end else begin
            m1_q <= we_q & (addr_q == rd_addr_rs1) & (rd_addr_rs1 != '0);
            m2_q <= we_q & (addr_q == rd_addr_rs2) & (rd_addr_rs2 != '0);
            wd_q <= data_q;
        end
    end

    assign fwd_data_rs1 = m1_q ? wd_q : rf_data_rs1;
    assign fwd_data_rs2 = m2_q ? wd_q : rf_data_rs2;
`else
    logic [2*ADDRW-1:0] unused_rd_addr_s;

    assign unused_rd_addr_s = {rd_addr_rs1, rd_addr_rs2};
    assign fwd_data_rs1     = rf_data_rs1;
    assign fwd_data_rs2     = rf_data_rs2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: predicted writes are queued at each handshake
// edge and compared against the write stage one cycle later.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_rd;
    logic [NR*DW-1:0]  req_data;
    logic              rf_write_enable;
    logic [AW-1:0]     rf_addr_rd;
    logic [DW-1:0]     rf_data_rd;
    logic [AW-1:0]     rd_addr_rs1, rd_addr_rs2;
    logic [DW-1:0]     rf_data_rs1, rf_data_rs2;
    logic [DW-1:0]     fwd_data_rs1, fwd_data_rs2;
    logic [(2**AW)-1:0] rd_pending;

    wr_t           sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            ptr_m   = 0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.DATAW(DW), .ADDRW(AW), .NUM_REQ(NR)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rd          (req_rd),
        .req_data        (req_data),
        .rf_write_enable (rf_write_enable),
        .rf_addr_rd      (rf_addr_rd),
        .rf_data_rd      (rf_data_rd),
        .rd_addr_rs1     (rd_addr_rs1),
        .rd_addr_rs2     (rd_addr_rs2),
        .rf_data_rs1     (rf_data_rs1),
        .rf_data_rs2     (rf_data_rs2),
        .fwd_data_rs1    (fwd_data_rs1),
        .fwd_data_rs2    (fwd_data_rs2),
        .rd_pending      (rd_pending)
    );

    function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int p);
        logic [NR-1:0] g;
        g = '0;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (p + k) % NR;
            if (v[idx] && (g == '0)) g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [(2**AW)-1:0] pend_of(input wr_t e);
        logic [(2**AW)-1:0] p;
        p = '0;
        if (e.we) p[e.addr] = 1'b1;
        return p;
    endfunction

    // Model the handshake about to happen at the next edge and queue its write-stage result.
    task automatic predict();
        logic [NR-1:0] g;
        wr_t           e;
        g = model_grant(req_valid, ptr_m);
        e.we   = 1'b0;
        e.addr = last_addr;
        e.data = last_data;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                ptr_m = (i + 1) % NR;
                if (req_rd[i*AW +: AW] != '0) begin
                    e.we      = 1'b1;
                    e.addr    = req_rd[i*AW +: AW];
                    e.data    = req_data[i*DW +: DW];
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic reset_model();
        wr_t e;
        sb_q.delete();
        ptr_m     = 0;
        last_addr = '0;
        last_data = '0;
        e = '0;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        req_valid   = 3'b111;
        req_rd      = {5'd3, 5'd2, 5'd1};
        req_data    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        rd_addr_rs1 = 5'd0;
        rd_addr_rs2 = 5'd0;
        rf_data_rs1 = 32'd0;
        rf_data_rs2 = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_tests++;
            if ({req_ready, rf_write_enable, rd_pending} !== {3'b000, 1'b0, 32'd0}) begin
                n_fail++;
                $display("FAIL reset cyc %0d: ready=%b we=%b pend=%h, want 000/0/0", k, req_ready, rf_write_enable, rd_pending);
            end
        end
        @(posedge clock); #1;
        req_valid = 3'b000;
        reset_n   = 1'b1;
        reset_model();
    endtask

    task automatic test_fairness();
        wr_t e;
        req_valid = 3'b111;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) req_valid = 3'b000;
            @(negedge clock);
            e = sb_q.pop_front();
            n_tests++;
            if ({rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending} !== {e.we, e.addr, e.data, pend_of(e)}) begin
                n_fail++;
                $display("FAIL fair_wr cyc %0d: got we=%b a=%0d d=%h, want we=%b a=%0d d=%h", k, rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.addr, e.data);
            end
            n_tests++;
            if (k < 6 && req_ready !== (3'b001 << (k % 3))) begin
                n_fail++;
                $display("FAIL fair_order cyc %0d: ready=%b want=%b", k, req_ready, 3'b001 << (k % 3));
            end
            predict();
            @(posedge clock); #1;
        end
    endtask

    task automatic test_single_write();
        wr_t e;
        req_valid = 3'b001;
        req_rd[0*AW +: AW]   = 5'd5;
        req_data[0*DW +: DW] = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            e = sb_q.pop_front();
            n_tests++;
            if ({rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending} !== {e.we, e.addr, e.data, pend_of(e)}) begin
                n_fail++;
                $display("FAIL single_wr cyc %0d: got we=%b a=%0d d=%h p=%h, want we=%b a=%0d d=%h", k, rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending, e.we, e.addr, e.data);
            end
            n_tests++;
            if (req_ready !== model_grant(req_valid, ptr_m)) begin
                n_fail++;
                $display("FAIL single_rdy cyc %0d: ready=%b want=%b", k, req_ready, model_grant(req_valid, ptr_m));
            end
            predict();
            @(posedge clock); #1;
            req_valid = 3'b000;
        end
    endtask

    task automatic test_x0_drop();
        wr_t e;
        req_valid = 3'b010;
        req_rd[1*AW +: AW]   = 5'd0;
        req_data[1*DW +: DW] = 32'h0000_1234;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            e = sb_q.pop_front();
            n_tests++;
            if ({rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending} !== {e.we, e.addr, e.data, pend_of(e)}) begin
                n_fail++;
                $display("FAIL x0_wr cyc %0d: got we=%b a=%0d d=%h p=%h, want we=%b a=%0d d=%h", k, rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending, e.we, e.addr, e.data);
            end
            n_tests++;
            if (req_ready !== model_grant(req_valid, ptr_m)) begin
                n_fail++;
                $display("FAIL x0_rdy cyc %0d: ready=%b want=%b", k, req_ready, model_grant(req_valid, ptr_m));
            end
            predict();
            @(posedge clock); #1;
            req_valid = 3'b000;
        end
    endtask

    task automatic test_bypass();
        wr_t           e;
        logic [DW-1:0] exp1, exp2;
        req_valid = 3'b100;
        req_rd[2*AW +: AW]   = 5'd7;
        req_data[2*DW +: DW] = 32'hA5A5_A5A5;
        rd_addr_rs1 = 5'd7;
        rd_addr_rs2 = 5'd7;
        rf_data_rs1 = 32'd0;
        rf_data_rs2 = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            e = sb_q.pop_front();
            n_tests++;
            if ({rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending} !== {e.we, e.addr, e.data, pend_of(e)}) begin
                n_fail++;
                $display("FAIL byp_wr cyc %0d: got we=%b a=%0d d=%h, want we=%b a=%0d d=%h", k, rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.addr, e.data);
            end
            exp1 = rf_data_rs1;
            exp2 = rf_data_rs2;
`ifdef WB_BYPASS_EN
            if (k == 2) begin
                exp1 = 32'hA5A5_A5A5;
                exp2 = 32'hA5A5_A5A5;
            end
`endif
            if (k > 0) begin
                n_tests++;
                if ({fwd_data_rs1, fwd_data_rs2} !== {exp1, exp2}) begin
                    n_fail++;
                    $display("FAIL bypass cyc %0d: fwd1=%h fwd2=%h, want %h %h", k, fwd_data_rs1, fwd_data_rs2, exp1, exp2);
                end
            end
            predict();
            @(posedge clock); #1;
            req_valid = 3'b000;
        end
        rd_addr_rs1 = 5'd0;
        rd_addr_rs2 = 5'd0;
    endtask

    task automatic test_back_to_back();
        wr_t           e;
        logic [NR-1:0] seen;
        seen = '0;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!(req_valid[i] && !seen[i])) begin
                    req_valid[i]         = ($urandom_range(0, 3) != 0);
                    req_rd[i*AW +: AW]   = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                    req_data[i*DW +: DW] = $urandom;
                end
            end
            @(negedge clock);
            e = sb_q.pop_front();
            n_tests++;
            if ({rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending} !== {e.we, e.addr, e.data, pend_of(e)}) begin
                n_fail++;
                $display("FAIL b2b_wr cyc %0d: got we=%b a=%0d d=%h p=%h, want we=%b a=%0d d=%h", k, rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending, e.we, e.addr, e.data);
            end
            n_tests++;
            if (req_ready !== model_grant(req_valid, ptr_m)) begin
                n_fail++;
                $display("FAIL b2b_rdy cyc %0d: ready=%b want=%b", k, req_ready, model_grant(req_valid, ptr_m));
            end
            seen = req_ready;
            predict();
            @(posedge clock); #1;
        end
        req_valid = 3'b000;
    endtask

    task automatic test_reset_midstream();
        wr_t e;
        req_valid = 3'b010;
        req_rd[1*AW +: AW]   = 5'd9;
        req_data[1*DW +: DW] = 32'hCAFE_0009;
        @(negedge clock);
        e = sb_q.pop_front();
        n_tests++;
        if ({rf_write_enable, rf_addr_rd, rf_data_rd} !== {e.we, e.addr, e.data}) begin
            n_fail++;
            $display("FAIL mid_pre: got we=%b a=%0d d=%h, want we=%b a=%0d d=%h", rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.addr, e.data);
        end
        predict();
        @(posedge clock); #1;
        n_tests++;
        if ({rf_write_enable, rf_addr_rd} !== {1'b1, 5'd9}) begin
            n_fail++;
            $display("FAIL mid_inflight: we=%b a=%0d, want 1 9", rf_write_enable, rf_addr_rd);
        end
        req_valid = 3'b111;
        req_rd    = {5'd12, 5'd11, 5'd10};
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({rf_write_enable, rd_pending, req_ready} !== {1'b0, 32'd0, 3'b000}) begin
            n_fail++;
            $display("FAIL mid_async: we=%b pend=%h ready=%b, want 0 0 000", rf_write_enable, rd_pending, req_ready);
        end
        @(posedge clock);
        @(posedge clock); #1;
        reset_n = 1'b1;
        reset_model();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            e = sb_q.pop_front();
            n_tests++;
            if ({rf_write_enable, rf_addr_rd, rf_data_rd, rd_pending} !== {e.we, e.addr, e.data, pend_of(e)}) begin
                n_fail++;
                $display("FAIL mid_post_wr cyc %0d: got we=%b a=%0d d=%h, want we=%b a=%0d d=%h", k, rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.addr, e.data);
            end
            n_tests++;
            if (req_ready !== ((k == 0) ? 3'b001 : model_grant(req_valid, ptr_m))) begin
                n_fail++;
                $display("FAIL mid_post_rdy cyc %0d: ready=%b want=%b", k, req_ready, (k == 0) ? 3'b001 : model_grant(req_valid, ptr_m));
            end
            predict();
            @(posedge clock); #1;
        end
        req_valid = 3'b000;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_write();
        test_x0_drop();
        test_bypass();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
